// File: rtl/disp_page_scheduler_pkg.sv
// Shared display definitions for the page scheduler.
//   page_t         2-bit page index, PAGE_PC/PAGE_RS/PAGE_RT/PAGE_RES = 0..3
//   ENABLE_OFF     all anodes off (active-low)
//   disp_state_e   scan FSM states; StBlank exists only with DISP_SCHED_BLANK_EN
//   digit_nibble   pick the hex nibble of a 16-bit snapshot for a digit
//   digit_enable   one-hot-low anode pattern for a digit
// Optional feature macro: DISP_SCHED_BLANK_EN (blank interval between digits).
package disp_page_scheduler_pkg;

  typedef logic [1:0] page_t;

  localparam page_t PAGE_PC  = 2'd0;
  localparam page_t PAGE_RS  = 2'd1;
  localparam page_t PAGE_RT  = 2'd2;
  localparam page_t PAGE_RES = 2'd3;

  localparam logic [3:0] ENABLE_OFF = 4'b1111;

`ifdef DISP_SCHED_BLANK_EN
  typedef enum logic {StScan = 1'b0, StBlank = 1'b1} disp_state_e;
`else
  typedef enum logic {StScan = 1'b0} disp_state_e;
`endif

  function automatic logic [3:0] digit_nibble(input logic [15:0] snap, input logic [1:0] digit);
    return snap[{digit, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] digit_enable(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// Counts frame boundaries in auto mode and flags when a page has dwelt long enough.
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   step_i   one pulse per frame boundary while rotating
//   clr_i    hold the count at zero (manual mode)
//   wrap_o   combinational: this step is the last frame of the page, count clears
module disp_dwell_timer #(
  parameter int unsigned Frames = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam logic [15:0] Last = 16'(Frames - 1);

  logic [15:0] count_q, count_d;

  assign wrap_o = step_i && !clr_i && (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (step_i) begin
      count_d = wrap_o ? '0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/disp_page_scheduler.sv
// Seven-segment page scheduler: scans four hex digits of a page snapshot, one
// step per tick, and picks the page shown in each frame (manual switches or
// automatic rotation after DWELL_FRAMES frames).
//   clk, Reset     clock, synchronous active-high reset
//   tick           scan-step strobe
//   auto_mode      1 = rotate pages, 0 = page from {SW_15,SW_14}
//   page0..page3   16-bit page data
//   Enable         active-low digit anodes
//   disp           nibble for the segment decoder
//   page           page currently shown
//   frame_done     one-clk pulse at each frame boundary
// Optional feature macro: DISP_SCHED_BLANK_EN inserts an all-off step after
// every lit digit (8 ticks per frame instead of 4).
module disp_page_scheduler
  import disp_page_scheduler_pkg::*;
#(
  parameter int unsigned DWELL_FRAMES = 256
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        tick,
  input  logic        auto_mode,
  input  logic        SW_15,
  input  logic        SW_14,
  input  logic [15:0] page0,
  input  logic [15:0] page1,
  input  logic [15:0] page2,
  input  logic [15:0] page3,
  output logic [3:0]  Enable,
  output logic [3:0]  disp,
  output logic [1:0]  page,
  output logic        frame_done
);

  disp_state_e state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  // Cleared by reset: the first tick lights digit 0 without being a boundary.
  logic        primed_q, primed_d;
  page_t       page_q, page_d;
  logic [15:0] snap_q, snap_d;
  logic [3:0]  enable_q, enable_d;
  logic [3:0]  disp_q, disp_d;
  logic        frame_done_q, frame_done_d;

  logic       go_blank;
  logic       light;
  logic       boundary;
  logic [1:0] next_digit;
  logic       dwell_wrap;

  disp_dwell_timer #(
    .Frames (DWELL_FRAMES)
  ) u_dwell_timer (
    .clk_i  (clk),
    .rst_i  (Reset),
    .step_i (boundary && auto_mode),
    .clr_i  (!auto_mode),
    .wrap_o (dwell_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= StScan;
      digit_q      <= 2'd0;
      primed_q     <= 1'b0;
      page_q       <= PAGE_PC;
      snap_q       <= '0;
      enable_q     <= ENABLE_OFF;
      disp_q       <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      primed_q     <= primed_d;
      page_q       <= page_d;
      snap_q       <= snap_d;
      enable_q     <= enable_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
`ifdef DISP_SCHED_BLANK_EN
    go_blank = tick && primed_q && (state_q == StScan);
`else
    go_blank = 1'b0;
`endif
    light      = tick && !go_blank;
    // A boundary is the lighting step that follows digit 3.
    boundary   = light && primed_q && (digit_q == 2'd3);
    next_digit = primed_q ? digit_q + 2'd1 : 2'd0;

    state_d  = state_q;
    digit_d  = digit_q;
    primed_d = primed_q;
`ifdef DISP_SCHED_BLANK_EN
    if (go_blank) begin
      state_d = StBlank;
    end else if (light) begin
      state_d = StScan;
    end
`endif
    if (light) begin
      digit_d  = next_digit;
      primed_d = 1'b1;
    end
  end

  // Output and datapath next values (all outputs are registered).
  always_comb begin
    page_d       = page_q;
    snap_d       = snap_q;
    enable_d     = enable_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;

    if (boundary) begin
      if (auto_mode) begin
        page_d = dwell_wrap ? page_q + 2'd1 : page_q;
      end else begin
        page_d = {SW_15, SW_14};
      end
      case (page_d)
        PAGE_PC:  snap_d = page0;
        PAGE_RS:  snap_d = page1;
        PAGE_RT:  snap_d = page2;
        PAGE_RES: snap_d = page3;
        default:  snap_d = page0;
      endcase
      frame_done_d = 1'b1;
    end

    if (go_blank) begin
      enable_d = ENABLE_OFF;
    end else if (light) begin
      // Uses snap_d so digit 0 of a new frame already shows the new page.
      enable_d = digit_enable(next_digit);
      disp_d   = digit_nibble(snap_d, next_digit);
    end
  end

  assign Enable     = enable_q;
  assign disp       = disp_q;
  assign page       = page_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_page_scheduler.sv
module tb_disp_page_scheduler;

  localparam int unsigned DW = 2;
`ifdef DISP_SCHED_BLANK_EN
  localparam int S     = 8;
  localparam bit BLANK = 1'b1;
`else
  localparam int S     = 4;
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset, tick, auto_mode, SW_15, SW_14;
  logic [15:0] page0, page1, page2, page3;
  logic [3:0]  Enable, disp;
  logic [1:0]  page;
  logic        frame_done;

  always #5 clk = ~clk;

  disp_page_scheduler #(
    .DWELL_FRAMES (DW)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .tick       (tick),
    .auto_mode  (auto_mode),
    .SW_15      (SW_15),
    .SW_14      (SW_14),
    .page0      (page0),
    .page1      (page1),
    .page2      (page2),
    .page3      (page3),
    .Enable     (Enable),
    .disp       (disp),
    .page       (page),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] dsp;
    logic [1:0] pg;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: position within the frame (-1 = nothing lit since reset).
  int          m_pos;
  int          m_dwell;
  logic [1:0]  m_page;
  logic [15:0] m_snap;
  logic [3:0]  m_en, m_disp;
  logic        m_fd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] pdata(input logic [1:0] p);
    case (p)
      2'd0:    return page0;
      2'd1:    return page1;
      2'd2:    return page2;
      default: return page3;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = -1; m_dwell = 0; m_page = 2'd0; m_snap = '0;
    m_en = 4'hF; m_disp = 4'h0; m_fd = 1'b0;
  endtask

  task automatic model_step(input logic t);
    int d;
    if (!auto_mode) m_dwell = 0;
    m_fd = 1'b0;
    if (t) begin
      if (m_pos == S - 1) begin
        if (auto_mode) begin
          if (m_dwell == int'(DW) - 1) begin
            m_page  = m_page + 2'd1;
            m_dwell = 0;
          end else begin
            m_dwell++;
          end
        end else begin
          m_page = {SW_15, SW_14};
        end
        m_snap = pdata(m_page);
        m_fd   = 1'b1;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
      if (BLANK && (m_pos % 2 == 1)) begin
        m_en = 4'hF;
      end else begin
        d      = m_pos / (S / 4);
        m_en   = 4'hF ^ (4'h1 << d);
        m_disp = m_snap[4*d +: 4];
      end
    end
  endtask

  // One clk cycle: drive tick, push the model's prediction, compare after the edge.
  task automatic cycle(input logic t);
    exp_t e;
    tick = t;
    model_step(t);
    e = '{en: m_en, dsp: m_disp, pg: m_page, fd: m_fd};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    e = sb_q.pop_front();
    check_val("enable", Enable, e.en);
    check_val("disp", disp, e.dsp);
    check_val("page", page, e.pg);
    check_val("frame_done", frame_done, e.fd);
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1);
      for (int g = 0; g < gap; g++) cycle(1'b0);
    end
  endtask

  // Reset for 3 clks with tick pulsing; reset must win throughout.
  task automatic do_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick = (i != 1);
      @(posedge clk);
      #1;
      check_val("rst_enable", Enable, 4'hF);
      check_val("rst_disp", disp, 4'h0);
      check_val("rst_page", page, 2'd0);
      check_val("rst_frame_done", frame_done, 1'b0);
    end
    tick  = 1'b0;
    Reset = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  logic [1:0] auto_seq [8];

  initial begin
    Reset = 1'b1; tick = 1'b0; auto_mode = 1'b0; SW_15 = 1'b0; SW_14 = 1'b0;
    page0 = 16'h0000; page1 = 16'h0000; page2 = 16'h1A2B; page3 = 16'hC0DE;
    model_reset();
    @(negedge clk);

    // Manual page 2: first frame shows snap=0, then B,2,A,1 on page 2.
    do_reset();
    SW_15 = 1'b1; SW_14 = 1'b0;
    run_ticks(S + 1, 1);
    check_val("man_page2", page, 2'd2);
    check_val("man_digit0", disp, 4'hB);
    run_ticks(2 * S - 1, 0);

    // Switch change after the digit-1 tick must not disturb the current frame.
    do_reset();
    page0 = 16'h5A3C;
    SW_15 = 1'b0; SW_14 = 1'b0;
    run_ticks(S + 1 + S / 4, 0);
    SW_15 = 1'b1; SW_14 = 1'b1;
    run_ticks(S - 1 - S / 4, 0);
    check_val("sw_hold_page", page, 2'd0);
    run_ticks(1, 0);
    check_val("sw_new_page", page, 2'd3);
    check_val("sw_new_fd", frame_done, 1'b1);
    run_ticks(S, 1);

    // Page data changing mid-frame shows only from the next frame.
    do_reset();
    page1 = 16'h0000;
    SW_15 = 1'b0; SW_14 = 1'b1;
    run_ticks(S + 1 + S / 2, 0);
    page1 = 16'hFFFF;
    run_ticks(S / 2 - 1, 0);
    check_val("data_hold", disp, 4'h0);
    run_ticks(1, 0);
    check_val("data_new", disp, 4'hF);
    run_ticks(S - 1, 0);

    // Auto rotation with two frames per page.
    auto_seq = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    page0 = 16'h0123; page1 = 16'h4567; page2 = 16'h89AB; page3 = 16'hCDEF;
    auto_mode = 1'b1;
    run_ticks(S, 0);
    for (int b = 0; b < 8; b++) begin
      cycle(1'b1);
      check_val("auto_page", page, auto_seq[b]);
      run_ticks(S - 1, 0);
    end

    // Random ticks, switches, mode changes and page data.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 9) == 0) begin
        SW_15 = 1'($urandom_range(0, 1));
        SW_14 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) begin
        page0 = 16'($urandom); page1 = 16'($urandom);
        page2 = 16'($urandom); page3 = 16'($urandom);
      end
      cycle(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
